digit_serial_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit. It processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first. A single DIGIT-wide adder slice is reused across cycles, with a registered carry between digits. A start/busy/done handshake lets a controller trade area for latency on wide datapaths where a flat ripple-carry adder is too large.

---
 rtl/digit_serial_adder.sv | 153 +++++++++++++++
 tb/tb_digit_serial_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle add/subtract unit. WIDTH-bit operands are processed DIGIT
//   bits per clock, least-significant digit first, through one reused
//   DIGIT-wide adder slice with a registered carry between digits.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high
//   start    : request pulse, accepted in IDLE or DONE
//   sub      : 0 = add, 1 = subtract (sampled with start)
//   a, b     : operands (sampled with start)
//   cin      : carry-in (add) / borrow-in (subtract) (sampled with start)
//   busy     : high while an operation is in progress
//   done     : one-cycle completion pulse
//   sum      : registered result
//   cout     : raw carry out of the MSB (subtract: 1 = no borrow)
//   overflow : two's-complement signed overflow
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("digit_serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               last_dig;
  logic [DIGIT:0]     dsum;

  // One digit slice: {carry_out, digit_sum} = x + y + c
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    digit_add = {1'b0, x} + {1'b0, y} + (DIGIT+1)'(c);
  endfunction

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_dig = (state_q == RUN) && (cnt_q == CNT_W'(NDIG - 1));
  assign dsum     = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], c_q);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_dig) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    part_d = part_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      // Subtract is a + ~b + 1 - cin, so the initial carry folds in sub.
      a_d    = a;
      b_d    = sub ? ~b : b;
      c_d    = cin ^ sub;
      cnt_d  = '0;
      part_d = '0;
    end else if (state_q == RUN) begin
      a_d    = a_q >> DIGIT;
      b_d    = b_q >> DIGIT;
      c_d    = dsum[DIGIT];
      cnt_d  = last_dig ? '0 : cnt_q + CNT_W'(1);
      // Result digits enter at the top and drift down; after NDIG digits
      // the partial register holds the full word in place.
      part_d = (part_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      if (last_dig) begin
        sum_d  = part_d;
        cout_d = dsum[DIGIT];
        // Carry into the MSB is recovered from the MSB sum bit.
        ovf_d  = dsum[DIGIT] ^ (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      part_q <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      part_q <= part_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                       input logic ms, output logic [15:0] es, output logic eco,
                       output logic eov);
    int ua, ub, tot, sa, sb, sr;
    ua  = int'(ma);
    ub  = ms ? (65535 - int'(mb)) : int'(mb);
    tot = ua + ub + int'(mc ^ ms);
    es  = tot[15:0];
    eco = tot[16];
    sa  = int'($signed(ma));
    sb  = int'($signed(mb));
    sr  = ms ? (sa - sb - int'(mc)) : (sa + sb + int'(mc));
    eov = (sr > 32767) || (sr < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input logic is);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 4 * NDIG + 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                               input logic ic, input logic is);
    logic [15:0] es;
    logic        eco, eov;
    model(ia, ib, ic, is, es, eco, eov);
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(eco));
    check({tag, "_ovf"},  32'(overflow), 32'(eov));
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is);
    int lat;
    logic [15:0] held;
    launch(ia, ib, ic, is);
    check({tag, "_busy_start"}, 32'(busy), 32'(1));
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(NDIG));
    expect_result(tag, ia, ib, ic, is);
    held = sum;
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'(0));
    check({tag, "_hold"}, 32'(sum), 32'(held));
  endtask

  initial begin
    int lat;
    int ndone;
    logic [15:0] ra, rb;
    logic        rc, rs;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum",  32'(sum),  32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_ovf",  32'(overflow), 32'(0));
    rst = 1'b0;
    tick();

    // Directed values with literal expectations
    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("add_basic_lit", 32'({sum, cout, overflow}), 32'({16'h2233, 1'b0, 1'b0}));
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("ripple_lit", 32'({sum, cout, overflow}), 32'({16'h0000, 1'b1, 1'b0}));
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("add_ovf_lit", 32'({sum, cout, overflow}), 32'({16'h8000, 1'b0, 1'b1}));
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
    check("sub_neg_lit", 32'({sum, cout, overflow}), 32'({16'hFFFE, 1'b0, 1'b0}));
    run_op("sub_ovf", 16'h8000, 16'h0000, 1'b1, 1'b1);
    check("sub_ovf_lit", 32'({sum, cout, overflow}), 32'({16'h7FFF, 1'b1, 1'b1}));

    // start during RUN is ignored
    launch(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    tick();
    a = 16'h5555; b = 16'h1111; sub = 1'b1; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("ign_sum", 32'(sum), 32'(16'h2233));
    check("ign_done", 32'(done), 32'(1));
    ndone = 0;
    for (int i = 0; i < 3 * NDIG; i++) begin
      tick();
      if (done) ndone++;
    end
    check("ign_single_done", 32'(ndone), 32'(0));

    // Back-to-back: start held in the DONE cycle
    launch(16'hA5A5, 16'h1111, 1'b0, 1'b0);
    wait_done(lat);
    expect_result("b2b_first", 16'hA5A5, 16'h1111, 1'b0, 1'b0);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'(1));
    check("b2b_no_done", 32'(done), 32'(0));
    wait_done(lat);
    check("b2b_latency", 32'(lat), 32'(NDIG));
    check("b2b_sum", 32'(sum), 32'(16'h0003));

    // Reset during the second RUN cycle aborts the operation
    tick();
    launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sum",  32'(sum),  32'(0));
    check("abort_cout", 32'(cout), 32'(0));
    check("abort_ovf",  32'(overflow), 32'(0));
    ndone = 0;
    for (int i = 0; i < 2 * NDIG + 2; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("abort_quiet", 32'(ndone), 32'(0));
    run_op("after_abort", 16'h1234, 16'h0FFF, 1'b0, 1'b0);

    // Randomized operations, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) rb = 16'hFFFF;
      launch(ra, rb, rc, rs);
      check("rnd_busy", 32'(busy), 32'(1));
      wait_done(lat);
      check("rnd_latency", 32'(lat), 32'(NDIG));
      expect_result("rnd", ra, rb, rc, rs);
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
